// File: rtl/mcycle_ctrl.sv
// Multi-cycle MUL/DIV sequencer for the EX stage: shift-add multiply and restoring divide,
// one bit per cycle. Define MCYCLE_EARLY_TERM_EN to let MUL finish once the multiplier runs out.
module mcycle_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_e;

    state_e               state_q,   state_d;
    logic [CW-1:0]        count_q,   count_d;
    logic                 is_div_q,  is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     op1_q,     op1_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic [WIDTH-1:0]     rem_q,     rem_d;
    logic [WIDTH-1:0]     quot_q,    quot_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [WIDTH-1:0]     result1_q, result1_d;
    logic [WIDTH-1:0]     result2_q, result2_d;

    logic                 sign1, sign2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [2*WIDTH-1:0]   acc_n, prod;
    logic [WIDTH-1:0]     mplier_n, rem_n, quot_n;
    logic [WIDTH:0]       r_ext, trial;
    logic                 last;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case infers a latch.
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        op1_d      = op1_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        result1_d  = result1_q;
        result2_d  = result2_q;

        sign1 = MCycleOp[1] & Operand1[WIDTH-1];
        sign2 = MCycleOp[1] & Operand2[WIDTH-1];
        mag1  = magnitude(Operand1, sign1);
        mag2  = magnitude(Operand2, sign2);

        // One multiply step and one divide step, always evaluated from the current state.
        acc_n    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_n = mplier_q >> 1;
        r_ext    = {rem_q, quot_q[WIDTH-1]};
        trial    = r_ext - {1'b0, divisor_q};
        rem_n    = trial[WIDTH] ? r_ext[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_n   = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
        prod     = neg_res_q ? -acc_n : acc_n;

`ifdef MCYCLE_EARLY_TERM_EN
        last = (count_q == '0) || (!is_div_q && (mplier_n == '0));
`else
        last = (count_q == '0);
`endif

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_COMPUTE;
                    count_d    = CW'(WIDTH - 1);
                    is_div_d   = MCycleOp[0];
                    neg_res_d  = sign1 ^ sign2;
                    neg_rem_d  = sign1;
                    div_zero_d = (Operand2 == '0);
                    op1_d      = Operand1;
                    acc_d      = '0;
                    mcand_d    = {{WIDTH{1'b0}}, mag1};
                    mplier_d   = mag2;
                    rem_d      = '0;
                    quot_d     = mag1;
                    divisor_d  = mag2;
                end
            end

            S_COMPUTE: begin
                count_d = count_q - CW'(1);
                if (is_div_q) begin
                    rem_d  = rem_n;
                    quot_d = quot_n;
                end else begin
                    acc_d    = acc_n;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_n;
                end

                if (last) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        result1_d = prod[WIDTH-1:0];
                        result2_d = prod[2*WIDTH-1:WIDTH];
                    end else if (div_zero_q) begin
                        // Divide by zero reports the raw dividend with no sign fix-up.
                        result1_d = '1;
                        result2_d = op1_q;
                    end else begin
                        result1_d = magnitude(quot_n, neg_res_q);
                        result2_d = magnitude(rem_n, neg_rem_q);
                    end
                end
            end

            S_DONE: begin
                // Start is still the stalled instruction here and must not relaunch.
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset along with control so an abort leaves no stale result.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            op1_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            result1_q  <= '0;
            result2_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            op1_q      <= op1_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            result1_q  <= result1_d;
            result2_q  <= result2_d;
        end
    end

    // Busy is combinational so the requesting instruction stalls in its own cycle.
    assign Busy    = RESETn & (((state_q == S_IDLE) & Start) | (state_q == S_COMPUTE));
    assign Done    = (state_q == S_DONE);
    assign Result1 = result1_q;
    assign Result2 = result2_q;

endmodule
